// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC rotation controller.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } cordic_state_t;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // Stage counter width; a single-stage build still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_iter_step.sv
// One CORDIC micro-rotation with a run-time shift amount (shared by all stages).
module cordic_iter_step
  import cordic_pkg::*;
#(
  parameter int W  = 22,
  parameter int SW = 4
) (
  input  logic signed [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic        [SW-1:0] i_shift,
  input  logic                 i_dir,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y
);

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;

  // Arithmetic shifts truncate toward -inf; sums wrap modulo 2^W.
  assign w_xs = i_x >>> i_shift;
  assign w_ys = i_y >>> i_shift;

  assign o_x = (i_dir == DIR_CCW) ? (i_x - w_ys) : (i_x + w_ys);
  assign o_y = (i_dir == DIR_CCW) ? (i_y + w_xs) : (i_y - w_xs);

endmodule

// File: rtl/cordic_rot_iter_ctrl.sv
// Iterative CORDIC rotation sequencer: latches one vector plus direction word,
// runs NUM_STAGES micro-rotations through one shared step, then holds the
// result until the consumer takes it. No gain compensation.
module cordic_rot_iter_ctrl
  import cordic_pkg::*;
#(
  parameter  int CORDIC_WIDTH = 22,
  parameter  int NUM_STAGES   = 16,
  localparam int CNT_W        = cnt_w(NUM_STAGES)
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic signed [CORDIC_WIDTH-1:0] x_in,
  input  logic signed [CORDIC_WIDTH-1:0] y_in,
  input  logic        [NUM_STAGES-1:0]   dir_in,
  input  logic                           abort,
  output logic signed [CORDIC_WIDTH-1:0] x_out,
  output logic signed [CORDIC_WIDTH-1:0] y_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic        [CNT_W-1:0]        stage_idx
);

  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(NUM_STAGES - 1);

  cordic_state_t                   r_state;
  logic signed [CORDIC_WIDTH-1:0]  r_x;
  logic signed [CORDIC_WIDTH-1:0]  r_y;
  logic        [NUM_STAGES-1:0]    r_dir;
  logic        [CNT_W-1:0]         r_stage;
  logic                            r_out_valid;
  logic                            r_busy;
  logic                            r_start_ready;

  logic signed [CORDIC_WIDTH-1:0]  w_x_nxt;
  logic signed [CORDIC_WIDTH-1:0]  w_y_nxt;

  cordic_iter_step #(
    .W  (CORDIC_WIDTH),
    .SW (CNT_W)
  ) u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_shift (r_stage),
    .i_dir   (r_dir[r_stage]),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt)
  );

  // Controller FSM: accept, iterate one stage per clock, hold result, handshake out.
  // abort outranks everything, including a same-cycle start.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= ST_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_dir         <= '0;
      r_stage       <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
    end else if (abort) begin
      r_state       <= ST_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_dir         <= '0;
      r_stage       <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_x           <= x_in;
            r_y           <= y_in;
            r_dir         <= dir_in;
            r_stage       <= '0;
            r_state       <= ST_ROTATE;
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
          end
        end
        ST_ROTATE: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          if (r_stage == LAST_STAGE) begin
            r_stage     <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_stage <= r_stage + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Return to IDLE only; the next start is taken on a later edge.
          if (out_ready) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_stage       <= '0;
          r_out_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  // Result is only visible while held in DONE.
  assign x_out       = r_out_valid ? r_x : '0;
  assign y_out       = r_out_valid ? r_y : '0;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign start_ready = r_start_ready;
  assign stage_idx   = r_stage;

endmodule

// File: tb/tb_cordic_rot_iter_ctrl.sv
// Directed bench: default build (22/16), a 4-stage build and an 8-bit 1-stage build.
module tb_cordic_rot_iter_ctrl;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // a_: default 22-bit / 16 stages
  logic               a_sv = 0, a_sr, a_ab = 0, a_ov, a_or = 0, a_busy;
  logic signed [21:0] a_x = 0, a_y = 0, a_xo, a_yo;
  logic        [15:0] a_d = 0;
  logic        [3:0]  a_si;
  // b_: 22-bit / 4 stages
  logic               b_sv = 0, b_sr, b_ab = 0, b_ov, b_or = 0, b_busy;
  logic signed [21:0] b_x = 0, b_y = 0, b_xo, b_yo;
  logic        [3:0]  b_d = 0;
  logic        [1:0]  b_si;
  // c_: 8-bit / 1 stage
  logic               c_sv = 0, c_sr, c_ab = 0, c_ov, c_or = 0, c_busy;
  logic signed [7:0]  c_x = 0, c_y = 0, c_xo, c_yo;
  logic        [0:0]  c_d = 0;
  logic        [0:0]  c_si;

  cordic_rot_iter_ctrl dut_a (
    .clk(clk), .nreset(nreset), .start_valid(a_sv), .start_ready(a_sr),
    .x_in(a_x), .y_in(a_y), .dir_in(a_d), .abort(a_ab),
    .x_out(a_xo), .y_out(a_yo), .out_valid(a_ov), .out_ready(a_or),
    .busy(a_busy), .stage_idx(a_si));

  cordic_rot_iter_ctrl #(.CORDIC_WIDTH(22), .NUM_STAGES(4)) dut_b (
    .clk(clk), .nreset(nreset), .start_valid(b_sv), .start_ready(b_sr),
    .x_in(b_x), .y_in(b_y), .dir_in(b_d), .abort(b_ab),
    .x_out(b_xo), .y_out(b_yo), .out_valid(b_ov), .out_ready(b_or),
    .busy(b_busy), .stage_idx(b_si));

  cordic_rot_iter_ctrl #(.CORDIC_WIDTH(8), .NUM_STAGES(1)) dut_c (
    .clk(clk), .nreset(nreset), .start_valid(c_sv), .start_ready(c_sr),
    .x_in(c_x), .y_in(c_y), .dir_in(c_d), .abort(c_ab),
    .x_out(c_xo), .y_out(c_yo), .out_valid(c_ov), .out_ready(c_or),
    .busy(c_busy), .stage_idx(c_si));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference rotation for the 22-bit / 16-stage build.
  task automatic ref_rot(input logic signed [21:0] xi, input logic signed [21:0] yi,
                         input logic [15:0] d,
                         output logic signed [21:0] xo, output logic signed [21:0] yo);
    logic signed [21:0] xs, ys;
    xo = xi; yo = yi;
    for (int i = 0; i < 16; i++) begin
      xs = xo >>> i;
      ys = yo >>> i;
      if (d[i]) begin xo = xo - ys; yo = yo + xs; end
      else      begin xo = xo + ys; yo = yo - xs; end
    end
  endtask

  int                 vx [4] = '{100000, -200000, 1048575, 0};
  int                 vy [4] = '{-50000, 300000, -1048576, 7};
  logic [15:0]        vd [4] = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h1234};
  logic signed [21:0] ex, ey;
  int                 cyc, last, pulses, seen;

  initial begin
    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_ov_low", a_ov, 0);
    chk("rst_busy_low", a_busy, 0);
    nreset = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", a_sr, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_x_out", a_xo, 0);
    chk("rst_y_out", a_yo, 0);
    chk("rst_stage_idx", a_si, 0);

    // 2: 4-stage rotation of (64,0), all dir 0
    b_sv = 1; b_x = 64; b_y = 0; b_d = 4'b0000;
    @(negedge clk);
    b_sv = 0;
    chk("t2_busy", b_busy, 1);
    chk("t2_start_ready", b_sr, 0);
    chk("t2_stage0", b_si, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("t2_stage_idx", b_si, k);
      chk("t2_ov_early", b_ov, 0);
    end
    @(negedge clk);
    chk("t2_ov_at_4", b_ov, 1);
    chk("t2_x", b_xo, -5);
    chk("t2_y", b_yo, -105);

    // 3: backpressure with a competing start
    b_sv = 1; b_x = 100; b_y = 0; b_d = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_ov", b_ov, 1);
      chk("t3_hold_x", b_xo, -5);
      chk("t3_hold_y", b_yo, -105);
      chk("t3_no_ready", b_sr, 0);
    end
    b_or = 1;
    @(negedge clk);
    chk("t3_idle_ov", b_ov, 0);
    chk("t3_idle_ready", b_sr, 1);
    chk("t3_idle_busy", b_busy, 0);
    @(negedge clk);
    chk("t3_accept_busy", b_busy, 1);
    chk("t3_accept_stage", b_si, 0);
    b_sv = 0; b_or = 0;
    repeat (3) @(negedge clk);
    chk("t3_ov_early", b_ov, 0);
    @(negedge clk);
    chk("t3_ov", b_ov, 1);
    chk("t3_x", b_xo, -9);
    chk("t3_y", b_yo, -163);
    b_or = 1;
    @(negedge clk);
    chk("t3_drain", b_ov, 0);
    b_or = 0;

    // 4: abort at stage 2, with a same-cycle start that must be ignored
    b_sv = 1; b_x = 64; b_y = 0; b_d = 4'b0000;
    @(negedge clk);
    b_sv = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_stage2", b_si, 2);
    b_ab = 1; b_sv = 1;
    @(negedge clk);
    b_ab = 0; b_sv = 0;
    chk("t4_busy", b_busy, 0);
    chk("t4_ready", b_sr, 1);
    chk("t4_stage", b_si, 0);
    chk("t4_x", b_xo, 0);
    chk("t4_y", b_yo, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b_ov || b_busy) seen++;
    end
    chk("t4_no_activity", seen, 0);
    b_sv = 1; b_x = 0; b_y = 64; b_d = 4'b1111;
    @(negedge clk);
    b_sv = 0;
    for (int k = 0; k < 10 && !b_ov; k++) @(negedge clk);
    chk("t4_restart_ov", b_ov, 1);
    chk("t4_restart_x", b_xo, -105);
    chk("t4_restart_y", b_yo, -5);
    b_or = 1;
    @(negedge clk);
    b_or = 0;

    // 5: streaming on the default build
    a_x = 22'(vx[0]); a_y = 22'(vy[0]); a_d = vd[0];
    a_sv = 1; a_or = 1;
    cyc = 0; last = 0; pulses = 0;
    while (pulses < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (a_ov) begin
        ref_rot(22'(vx[pulses]), 22'(vy[pulses]), vd[pulses], ex, ey);
        chk("t5_x", a_xo, ex);
        chk("t5_y", a_yo, ey);
        if (pulses > 0) chk("t5_period", cyc - last, 18);
        last = cyc;
        pulses++;
        if (pulses < 4) begin
          a_x = 22'(vx[pulses]); a_y = 22'(vy[pulses]); a_d = vd[pulses];
        end else begin
          a_sv = 0;
        end
      end
    end
    chk("t5_pulses", pulses, 4);
    a_sv = 0;
    @(negedge clk);
    chk("t5_pulse_width", a_ov, 0);
    a_or = 0;

    // 6: 8-bit single-stage wrap
    c_sv = 1; c_x = 127; c_y = 127; c_d = 1'b0;
    @(negedge clk);
    c_sv = 0;
    chk("t6_busy", c_busy, 1);
    chk("t6_ov_early", c_ov, 0);
    @(negedge clk);
    chk("t6_ov", c_ov, 1);
    chk("t6_x_wrap", c_xo, -2);
    chk("t6_y", c_yo, 0);
    c_or = 1;
    @(negedge clk);
    chk("t6_drain", c_ov, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
